// File: rtl/ga.sv
// ga: hardware genetic algorithm maximising x^3 over CHROM_WIDTH-bit genes.
// LFSR-driven tournament selection, single-cut crossover, 1/16 mutation.
module ga #(
  parameter int POP_SIZE      = 32,
  parameter int GENS          = 1000,
  parameter int CHROM_WIDTH   = 16,
  parameter int FITNESS_WIDTH = (CHROM_WIDTH + 1) * 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              seed,
  output logic [CHROM_WIDTH-1:0]   best,
  output logic [FITNESS_WIDTH-1:0] best_fit,
  output logic                     finished
);

  localparam int CW  = CHROM_WIDTH;
  localparam int FW  = FITNESS_WIDTH;
  localparam int PW  = $clog2(POP_SIZE);
  localparam int CL  = $clog2(CHROM_WIDTH);
  localparam int GW  = $clog2(GENS + 1);
  localparam int CUT = 4 * PW;
  localparam int MP  = CUT + CL;
  localparam int MT  = MP + CL;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    INIT, EVAL, NEXTGEN, BREED, COPY, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   index_q, index_d;
  logic [GW-1:0]   gen_counter, gen_d;
  logic [CW-1:0]   best_q, best_d;
  logic [FW-1:0]   bfit_q, bfit_d;
  logic            fin_q, fin_d;
  logic [31:0]     lfsr_q, lfsr_nxt;

  logic [CW-1:0]   pop_q  [POP_SIZE];
  logic [FW-1:0]   fitv_q [POP_SIZE];
  logic [CW-1:0]   nxt_q  [POP_SIZE];

  logic [PW-1:0]   idx_a, idx_b, idx_c, idx_d;
  logic [CL-1:0]   cut, mpos;
  logic [3:0]      mtest;
  logic [CW-1:0]   pa, pb, mask, flip, child;
  logic [FW-1:0]   cur_x, fit_cur;
  logic            last;

  assign lfsr_nxt = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS)
                              : (lfsr_q >> 1);

  assign idx_a = lfsr_q[0 +: PW];
  assign idx_b = lfsr_q[PW +: PW];
  assign idx_c = lfsr_q[2*PW +: PW];
  assign idx_d = lfsr_q[3*PW +: PW];
  assign cut   = lfsr_q[CUT +: CL];
  assign mpos  = lfsr_q[MP +: CL];
  assign mtest = lfsr_q[MT +: 4];

  assign cur_x   = FW'(pop_q[index_q]);
  assign fit_cur = cur_x * cur_x * cur_x;
  assign last    = (index_q == PW'(POP_SIZE - 1));

  // ties keep the first contender of each pair
  assign pa = (fitv_q[idx_b] > fitv_q[idx_a]) ? pop_q[idx_b]
                                              : pop_q[idx_a];
  assign pb = (fitv_q[idx_d] > fitv_q[idx_c]) ? pop_q[idx_d]
                                              : pop_q[idx_c];
  assign mask  = (CW'(1) << cut) - CW'(1);
  assign flip  = (mtest == 4'd0) ? (CW'(1) << mpos) : '0;
  assign child = ((pa & mask) | (pb & ~mask)) ^ flip;

  assign best     = best_q;
  assign best_fit = bfit_q;
  assign finished = fin_q;

  // next-state and result logic of the generation sequencer
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    gen_d   = gen_counter;
    best_d  = best_q;
    bfit_d  = bfit_q;
    fin_d   = fin_q;
    case (state_q)
      INIT: begin
        index_d = index_q + PW'(1);
        if (last) begin
          state_d = EVAL;
          index_d = '0;
        end
      end
      EVAL: begin
        index_d = index_q + PW'(1);
        if (fit_cur > bfit_q) begin
          best_d = pop_q[index_q];
          bfit_d = fit_cur;
        end
        if (last) state_d = NEXTGEN;
      end
      NEXTGEN: begin
        gen_d   = gen_counter + GW'(1);
        index_d = '0;
        if (gen_d == GW'(GENS)) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end else begin
          state_d = BREED;
        end
      end
      BREED: begin
        index_d = index_q + PW'(1);
        if (last) state_d = COPY;
      end
      COPY: begin
        state_d = EVAL;
        index_d = '0;
      end
      DONE: ;
      default: state_d = INIT;
    endcase
  end

  // control registers and LFSR with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      index_q     <= '0;
      gen_counter <= '0;
      best_q      <= '0;
      bfit_q      <= '0;
      fin_q       <= 1'b0;
      lfsr_q      <= (seed == 32'd0) ? 32'd1 : seed;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      gen_counter <= gen_d;
      best_q      <= best_d;
      bfit_q      <= bfit_d;
      fin_q       <= fin_d;
      lfsr_q      <= lfsr_nxt;
    end
  end

  // population, fitness and offspring storage
  always_ff @(posedge clk) begin
    if (!reset) begin
      case (state_q)
        INIT:  pop_q[index_q]  <= lfsr_q[CW-1:0];
        EVAL:  fitv_q[index_q] <= fit_cur;
        BREED: nxt_q[index_q]  <= (index_q == '0) ? best_q
                                                  : child;
        COPY:  pop_q <= nxt_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ga.sv
// tb_ga: randomized-seed checks of ga against an algorithmic GA model.
// Compares best, best_fit, finished and gen_counter every cycle.
module tb_ga;

  localparam int POP  = 8;
  localparam int GENS = 6;
  localparam int CW   = 16;
  localparam int FW   = (CW + 1) * 3;
  localparam int TOT  = POP + GENS * (POP + 1)
                      + (GENS - 1) * (POP + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   seed;
  logic [CW-1:0] best;
  logic [FW-1:0] best_fit;
  logic          finished;

  int n_vec = 0;
  int n_err = 0;

  ga #(
    .POP_SIZE(POP), .GENS(GENS), .CHROM_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .seed(seed),
    .best(best), .best_fit(best_fit), .finished(finished)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input longint unsigned got,
                       input longint unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model: whole GA run as a per-cycle trace ----
  longint unsigned e_best[$];
  longint unsigned e_fit[$];
  longint unsigned e_fin[$];
  longint unsigned e_gen[$];
  logic [31:0]     m_lfsr;
  int unsigned     m_pop[POP];
  int unsigned     m_nxt[POP];
  longint unsigned m_fit[POP];
  longint unsigned mb, mf, mfin, mg;

  function automatic logic [31:0] adv(input logic [31:0] r);
    return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
  endfunction

  task automatic push();
    m_lfsr = adv(m_lfsr);
    e_best.push_back(mb);
    e_fit.push_back(mf);
    e_fin.push_back(mfin);
    e_gen.push_back(mg);
  endtask

  function automatic int unsigned pick(input int unsigned i,
                                       input int unsigned j);
    return (m_fit[j] > m_fit[i]) ? m_pop[j] : m_pop[i];
  endfunction

  task automatic run_model(input logic [31:0] s);
    longint unsigned x, f;
    int unsigned r, ia, ib, ic, id, ct, mp, mt, pa, pb, mk, ch;
    e_best.delete(); e_fit.delete();
    e_fin.delete();  e_gen.delete();
    m_lfsr = (s == 0) ? 32'd1 : s;
    mb = 0; mf = 0; mfin = 0; mg = 0;
    for (int i = 0; i < POP; i++) begin
      m_pop[i] = m_lfsr % (1 << CW);
      push();
    end
    for (int g = 1; g <= GENS; g++) begin
      for (int i = 0; i < POP; i++) begin
        x = m_pop[i];
        f = x * x * x;
        m_fit[i] = f;
        if (f > mf) begin mf = f; mb = x; end
        push();
      end
      mg = g;
      if (g == GENS) mfin = 1;
      push();
      if (g == GENS) break;
      for (int i = 0; i < POP; i++) begin
        if (i == 0) m_nxt[0] = int'(mb);
        else begin
          r  = m_lfsr;
          ia = r % POP; r = r / POP;
          ib = r % POP; r = r / POP;
          ic = r % POP; r = r / POP;
          id = r % POP; r = r / POP;
          ct = r % CW;  r = r / CW;
          mp = r % CW;  r = r / CW;
          mt = r % 16;
          pa = pick(ia, ib);
          pb = pick(ic, id);
          mk = (1 << ct) - 1;
          ch = ((pa & mk) | (pb & ~mk)) % (1 << CW);
          if (mt == 0) ch = ch ^ (1 << mp);
          m_nxt[i] = ch;
        end
        push();
      end
      m_pop = m_nxt;
      push();
    end
  endtask

  // ---- DUT stimulus helpers ----
  task automatic check_reset(input string tag);
    check({tag, "_best"}, best, 0);
    check({tag, "_fit"},  best_fit, 0);
    check({tag, "_fin"},  finished, 0);
    check({tag, "_gen"},  dut.gen_counter, 0);
  endtask

  task automatic run_trace(input int n, input bit rise_chk);
    int k2, rise;
    rise = -1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      k2 = (k < e_best.size()) ? k : e_best.size() - 1;
      check($sformatf("best@%0d", k + 1), best, e_best[k2]);
      check($sformatf("fit@%0d", k + 1), best_fit, e_fit[k2]);
      check($sformatf("fin@%0d", k + 1), finished, e_fin[k2]);
      check($sformatf("gen@%0d", k + 1),
            dut.gen_counter, e_gen[k2]);
      if (finished && rise < 0) rise = k + 1;
    end
    if (rise_chk) check("fin_cycle", rise, TOT);
  endtask

  task automatic do_run(input logic [31:0] s, input int extra);
    seed  = s;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    run_model(s);
    reset = 1'b0;
    run_trace(TOT + extra, 1'b1);
  endtask

  initial begin
    logic [31:0] s;
    reset = 1'b1;
    seed  = 32'h895C_80A7;
    repeat (3) @(posedge clk);
    #1;
    check_reset("init");

    // reference seed, then 100 cycles held in DONE
    do_run(32'h895C_80A7, 100);

    // zero seed behaves as seed 1
    do_run(32'd0, 4);
    do_run(32'd1, 4);

    // reset asserted in the middle of EVAL
    s = $urandom;
    do_run(s, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    run_model(s);
    run_trace(POP + 3, 1'b0);
    s = $urandom;
    seed  = s;
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset("mid");
    run_model(s);
    reset = 1'b0;
    run_trace(TOT + 5, 1'b1);

    // random seeds
    for (int t = 0; t < 5; t++) begin
      do_run($urandom, 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
